// File: rtl/acc_seq_pkg.sv
// ============================================================================
// Module  : acc_seq_pkg
// Brief   : Opcode/state enums, ALU op constants and control bundle type for
//           the accumulator sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_LDR  = 3'b010,
    OP_STR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_JZ   = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] c_alu_pass = 2'b00;
  localparam logic [1:0] c_alu_add  = 2'b01;
  localparam logic [1:0] c_alu_sub  = 2'b10;

  typedef struct packed {
    logic       load_acc;
    logic       dump_acc;
    logic       sel_acc0;
    logic       sel_acc1;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/acc_seq_decode.sv
// ============================================================================
// Module  : acc_seq_decode
// Brief   : Combinational opcode-to-accumulator-control mapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_seq_decode
  import acc_seq_pkg::*;
(
  input  opcode_t i_opcode,
  output ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = c_alu_pass;
    case (i_opcode)
      OP_LDI: o_ctrl.load_acc = 1'b1;
      OP_LDR: begin
        o_ctrl.load_acc = 1'b1;
        o_ctrl.sel_acc0 = 1'b1;
      end
      OP_STR: o_ctrl.dump_acc = 1'b1;
      OP_ADD: begin
        o_ctrl.load_acc = 1'b1;
        o_ctrl.sel_acc1 = 1'b1;
        o_ctrl.alu_op   = c_alu_add;
      end
      OP_SUB: begin
        o_ctrl.load_acc = 1'b1;
        o_ctrl.sel_acc1 = 1'b1;
        o_ctrl.alu_op   = c_alu_sub;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/acc_sequencer.sv
// ============================================================================
// Module  : acc_sequencer
// Brief   : FETCH/EXEC/WB/HALT sequencer driving an accumulator datapath.
//           Optional single-step gating via macro ACC_SEQ_STEP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int OPND_W = 5
) (
  input  logic            clk,
  input  logic            reset,
`ifdef ACC_SEQ_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      instr,
  input  logic            acc_zero,
  output logic [PC_W-1:0] pc,
  output logic            LoadAcc,
  output logic            DumpAcc,
  output logic            SelAcc0,
  output logic            SelAcc1,
  output logic [1:0]      alu_op,
  output logic [1:0]      reg_sel,
  output logic            reg_we,
  output logic [7:0]      imm,
  output logic            halted
);

  state_t          r_state;
  logic [7:0]      r_ir;
  logic [PC_W-1:0] r_pc;
  ctrl_t           r_ctrl;
  logic [1:0]      r_reg_sel;
  logic            r_reg_we;
  logic [7:0]      r_imm;
  logic            r_halted;

  ctrl_t           w_ctrl;
  logic            w_go;
  opcode_t         w_ir_op;
  logic [PC_W-1:0] w_ir_target;

`ifdef ACC_SEQ_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  assign w_ir_op     = opcode_t'(r_ir[7:5]);
  assign w_ir_target = PC_W'(r_ir[OPND_W-1:0]);

  // Decode the ROM word during FETCH so controls are registered into EXEC.
  acc_seq_decode u_decode (
    .i_opcode (opcode_t'(instr[7:5])),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_ctrl    <= '0;
      r_reg_sel <= '0;
      r_reg_we  <= 1'b0;
      r_imm     <= '0;
      r_halted  <= 1'b0;
    end else begin
      r_ctrl    <= '0;
      r_reg_sel <= '0;
      r_reg_we  <= 1'b0;
      r_imm     <= '0;
      case (r_state)
        ST_FETCH: begin
          if (w_go) begin
            r_ir      <= instr;
            r_state   <= ST_EXEC;
            r_ctrl    <= w_ctrl;
            r_reg_sel <= instr[1:0];
            r_imm     <= 8'(instr[OPND_W-1:0]);
          end
        end
        ST_EXEC: begin
          if (w_ir_op == OP_HALT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc <= (w_ir_op == OP_JZ && acc_zero) ? w_ir_target : r_pc + PC_W'(1);
            if (w_ir_op == OP_STR) begin
              // Register file write lands one cycle after DumpAcc.
              r_state   <= ST_WB;
              r_reg_we  <= 1'b1;
              r_reg_sel <= r_reg_sel;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign pc      = r_pc;
  assign LoadAcc = r_ctrl.load_acc;
  assign DumpAcc = r_ctrl.dump_acc;
  assign SelAcc0 = r_ctrl.sel_acc0;
  assign SelAcc1 = r_ctrl.sel_acc1;
  assign alu_op  = r_ctrl.alu_op;
  assign reg_sel = r_reg_sel;
  assign reg_we  = r_reg_we;
  assign imm     = r_imm;
  assign halted  = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_acc_sequencer.sv
// ============================================================================
// Module  : tb_acc_sequencer
// Brief   : Self-checking bench; instruction-level reference model over a ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr;
  logic       acc_zero = 1'b0;
  logic [7:0] pc;
  logic       LoadAcc, DumpAcc, SelAcc0, SelAcc1, reg_we, halted;
  logic [1:0] alu_op, reg_sel;
  logic [7:0] imm;
`ifdef ACC_SEQ_STEP_EN
  logic       step = 1'b1;
`endif

  logic [7:0] mem [256];
  logic [7:0] pc_m;
  int         n_checks = 0;
  int         n_pass = 0;

  assign instr = mem[pc];

  acc_sequencer #(.PC_W(8), .OPND_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef ACC_SEQ_STEP_EN
    .step     (step),
`endif
    .instr    (instr),
    .acc_zero (acc_zero),
    .pc       (pc),
    .LoadAcc  (LoadAcc),
    .DumpAcc  (DumpAcc),
    .SelAcc0  (SelAcc0),
    .SelAcc1  (SelAcc1),
    .alu_op   (alu_op),
    .reg_sel  (reg_sel),
    .reg_we   (reg_we),
    .imm      (imm),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {LoadAcc,DumpAcc,SelAcc0,SelAcc1,alu_op,reg_sel,reg_we,imm,halted}
  function automatic logic [17:0] obs();
    return {LoadAcc, DumpAcc, SelAcc0, SelAcc1, alu_op, reg_sel, reg_we, imm, halted};
  endfunction

  // Expected EXEC-cycle outputs from the instruction table.
  function automatic logic [17:0] exp_exec(input logic [7:0] ins);
    logic [3:0] c;
    logic [1:0] a;
    c = 4'b0000;
    a = 2'b00;
    case (ins[7:5])
      3'd1: c = 4'b1000;
      3'd2: c = 4'b1010;
      3'd3: c = 4'b0100;
      3'd4: begin c = 4'b1001; a = 2'b01; end
      3'd5: begin c = 4'b1001; a = 2'b10; end
      default: ;
    endcase
    return {c, a, ins[1:0], 1'b0, {3'b000, ins[4:0]}, 1'b0};
  endfunction

  function automatic logic [17:0] exp_wb(input logic [7:0] ins);
    return {6'b0, ins[1:0], 1'b1, 8'h00, 1'b0};
  endfunction

  // Entered and left on a negedge with the DUT in FETCH; az<0 means random acc_zero.
  task automatic run_instr(input int az);
    logic [7:0] ins;
    logic       z;
    ins = mem[pc_m];
    acc_zero = 1'($urandom);
    check("fetch_pc", 32'(pc), 32'(pc_m));
    check("fetch_ctrl", 32'(obs()), 32'h0);
    @(negedge clk);
    check("exec_ctrl", 32'(obs()), 32'(exp_exec(ins)));
    check("exec_pc", 32'(pc), 32'(pc_m));
    z = (az < 0) ? 1'($urandom) : (az != 0);
    acc_zero = z;
    @(negedge clk);
    if (ins[7:5] == 3'd3) begin
      check("wb_ctrl", 32'(obs()), 32'(exp_wb(ins)));
      @(negedge clk);
    end
    if (ins[7:5] == 3'd6 && z) pc_m = {3'b000, ins[4:0]};
    else if (ins[7:5] != 3'd7) pc_m = pc_m + 8'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_ctrl", 32'(obs()), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pc_m = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge clk);
    do_reset();

    // LDI 5, STR r2, JZ 0x10 taken, then JZ 0x10 not taken, then HALT
    mem[8'h00] = 8'b001_00101;
    mem[8'h01] = 8'b011_00010;
    mem[8'h02] = 8'b110_10000;
    mem[8'h10] = 8'b110_10000;
    mem[8'h11] = 8'b111_00000;
    run_instr(-1);
    check("ldi_pc", 32'(pc), 32'h01);
    run_instr(-1);
    check("str_pc", 32'(pc), 32'h02);
    run_instr(1);
    check("jz_taken_pc", 32'(pc), 32'h10);
    run_instr(0);
    check("jz_not_taken_pc", 32'(pc), 32'h11);
    run_instr(-1);
    for (int k = 0; k < 10; k++) begin
      acc_zero = 1'($urandom);
      check("halt_ctrl", 32'(obs()), 32'h1);
      check("halt_pc", 32'(pc), 32'h11);
      @(negedge clk);
    end
    do_reset();
    check("post_halt_ctrl", 32'(obs()), 32'h0);

    // Reset during EXEC of STR: no write-back, restart at 0
    mem[8'h00] = 8'b011_00011;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_exec_we", 32'(reg_we), 32'h0);
    check("rst_exec_pc", 32'(pc), 32'h0);
    reset = 1'b0;
    pc_m = 8'h00;
    run_instr(-1);

    // Wrap-around through NOPs
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    do_reset();
    for (int i = 0; i < 256; i++) run_instr(-1);
    check("wrap_pc", 32'(pc), 32'h00);

    // Random program without HALT
    for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 5'($urandom)};
    do_reset();
    for (int i = 0; i < 300; i++) run_instr(-1);

`ifdef ACC_SEQ_STEP_EN
    mem[8'h00] = 8'b001_01010;
    reset = 1'b1;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("step_idle_pc", 32'(pc), 32'h0);
      check("step_idle_ctrl", 32'(obs()), 32'h0);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_exec_ctrl", 32'(obs()), 32'(exp_exec(mem[8'h00])));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("step_one_pc", 32'(pc), 32'h01);
      check("step_one_ctrl", 32'(obs()), 32'h0);
    end
    step = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
